// File: rtl/d_flip_flop.sv
// d_flip_flop: WIDTH-bit D-type storage element with complementary outputs,
// asynchronous active-high reset and asynchronous active-high set.
// Priority, highest first: reset, set, clock capture. Both asserted is
// flagged on sr_conflict.
// Optional build macro DFF_CLOCK_ENABLE_EN adds a ce input that gates the
// rising-edge capture. The asynchronous reset and set ignore ce.
module d_flip_flop #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic [WIDTH-1:0] d,
`ifdef DFF_CLOCK_ENABLE_EN
  input  logic             ce,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             sr_conflict
);

  logic [WIDTH-1:0] r_q;
  logic             w_set_only;
  logic             w_capture;

  // Set acts only while reset is low. Using the gated form as the async
  // event means reset falling with set still high raises w_set_only. That
  // loads all ones immediately, like a level-sensitive set/reset cell.
  assign w_set_only = set & ~reset;

`ifdef DFF_CLOCK_ENABLE_EN
  assign w_capture = ce;
`else
  assign w_capture = 1'b1;
`endif

  // State register: async clear, async preset, else capture d on rising clk.
  always_ff @(posedge clk or posedge reset or posedge w_set_only) begin
    if (reset) begin
      r_q <= '0;
    end else if (w_set_only) begin
      r_q <= '1;
    end else if (w_capture) begin
      r_q <= d;
    end
  end

  assign q           = r_q;
  assign qbar        = ~r_q;
  assign sr_conflict = reset & set;

endmodule

// File: tb/tb_d_flip_flop.sv
// tb_d_flip_flop: table-driven directed vectors applied to a WIDTH=1 and a
// WIDTH=8 instance in parallel, plus short hand-written sequences.
module tb_d_flip_flop;

  logic       clk;
  logic       reset;
  logic       set;
  logic [7:0] d;
  logic       ce;
  logic [0:0] q1, qbar1;
  logic [7:0] q8, qbar8;
  logic       conf1, conf8;

  int n_vec;
  int n_err;

  d_flip_flop #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .set(set), .d(d[0:0]),
`ifdef DFF_CLOCK_ENABLE_EN
    .ce(ce),
`endif
    .q(q1), .qbar(qbar1), .sr_conflict(conf1)
  );

  d_flip_flop #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .set(set), .d(d),
`ifdef DFF_CLOCK_ENABLE_EN
    .ce(ce),
`endif
    .q(q8), .qbar(qbar8), .sr_conflict(conf8)
  );

  typedef struct {
    logic       rst;
    logic       st;
    logic [7:0] d;
    logic       edg;
    logic [7:0] q;
    logic       conf;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] exp_q, input logic exp_conf);
    check({tag, " q1"},    {7'b0, q1},     {7'b0, exp_q[0]});
    check({tag, " qbar1"}, {7'b0, qbar1},  {7'b0, ~exp_q[0]});
    check({tag, " conf1"}, {7'b0, conf1},  {7'b0, exp_conf});
    check({tag, " q8"},    q8,             exp_q);
    check({tag, " qbar8"}, qbar8,          ~exp_q);
    check({tag, " conf8"}, {7'b0, conf8},  {7'b0, exp_conf});
  endtask

  // One rising edge; outputs sampled 1 time unit after it.
  task automatic pulse_and_check(input string tag, input logic [7:0] exp_q, input logic exp_conf);
    #2 clk = 1'b1;
    #1 check_all(tag, exp_q, exp_conf);
    #2 clk = 1'b0;
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    clk   = 1'b0;
    reset = 1'b0;
    set   = 1'b0;
    d     = 8'h00;
    ce    = 1'b1;

    //          rst   st    d      edge  q      conf
    vecs[0]  = '{1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 8'hA5, 1'b0, 8'h00, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 8'hA5, 1'b1, 8'hA5, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 8'hA5, 1'b0, 8'h00, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 8'hA5, 1'b1, 8'h00, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 8'hA5, 1'b0, 8'h00, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 8'hA5, 1'b1, 8'hA5, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 8'h3C, 1'b0, 8'hA5, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 8'h3C, 1'b1, 8'h3C, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 8'h3C, 1'b0, 8'hFF, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 8'h00, 1'b1, 8'hFF, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'hFF, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 8'h00, 1'b0, 8'hFF, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1};
    vecs[15] = '{1'b0, 1'b1, 8'h00, 1'b0, 8'hFF, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'hFF, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0};
    vecs[18] = '{1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1};
    vecs[19] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 8'h5A, 1'b0, 8'h00, 1'b0};
    vecs[21] = '{1'b0, 1'b0, 8'h5A, 1'b1, 8'h5A, 1'b0};

    #5;
    for (int i = 0; i < NVEC; i++) begin
      reset = vecs[i].rst;
      set   = vecs[i].st;
      d     = vecs[i].d;
      if (vecs[i].edg) begin
        pulse_and_check($sformatf("vec%0d", i), vecs[i].q, vecs[i].conf);
      end else begin
        #1 check_all($sformatf("vec%0d", i), vecs[i].q, vecs[i].conf);
        #4;
      end
    end

    // A short set pulse between edges leaves all ones stored.
    reset = 1'b1; #1 reset = 1'b0; #1;
    check_all("pre_setpulse", 8'h00, 1'b0);
    set = 1'b1; #1 set = 1'b0; #1;
    check_all("setpulse_hold", 8'hFF, 1'b0);

    // Conflict resolved by set releasing first: reset stays in control.
    set = 1'b1; reset = 1'b1; #1;
    set = 1'b0; #1;
    check_all("conflict_set_first", 8'h00, 1'b0);
    reset = 1'b0; #1;
    check_all("conflict_rst_after", 8'h00, 1'b0);

    // Conflict resolved by reset releasing first, then set: ones must persist.
    set = 1'b1; reset = 1'b1; #1;
    reset = 1'b0; #1;
    check_all("conflict_rst_first", 8'hFF, 1'b0);
    set = 1'b0; d = 8'h81; #1;
    check_all("conflict_set_after", 8'hFF, 1'b0);
    pulse_and_check("capture_after_conflict", 8'h81, 1'b0);

`ifdef DFF_CLOCK_ENABLE_EN
    reset = 1'b1; #1 reset = 1'b0; #1;
    ce = 1'b0; d = 8'hFF;
    pulse_and_check("ce0_hold", 8'h00, 1'b0);
    ce = 1'b1;
    pulse_and_check("ce1_capture", 8'hFF, 1'b0);
    ce = 1'b0; reset = 1'b1; #1;
    check_all("ce0_reset", 8'h00, 1'b0);
    reset = 1'b0; set = 1'b1; #1;
    check_all("ce0_set", 8'hFF, 1'b0);
    set = 1'b0; d = 8'h00;
    pulse_and_check("ce0_hold_ones", 8'hFF, 1'b0);
    ce = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
